// File: rtl/baud_pkg.sv
// Shared widths, the divisor record and the reset-divisor helper for the UART baud generator.
package baud_pkg;

  localparam int BAUD_CNT_W  = 16;
  localparam int BAUD_FRAC_W = 4;

  typedef struct packed {
    logic [BAUD_CNT_W-1:0]  ip;
    logic [BAUD_FRAC_W-1:0] fp;
  } baud_div_t;

  // frac = 0 gives the integer divisor; frac = FRAC_W gives the fixed-point one.
  function automatic int def_div(input longint clk_hz, input longint baud, input int frac);
    return int'((clk_hz <<< frac) / baud);
  endfunction

endpackage

// File: rtl/baud_ovs_div.sv
// Oversample strobe divider: one pulse every `period` cycles, at most OVS pulses per bit.
module baud_ovs_div #(
  parameter int CNT_W = 16,
  parameter int OVS   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             pulse
);

  localparam int NW = $clog2(OVS + 1);

  logic [CNT_W-1:0] sub_q;
  logic [NW-1:0]    n_q;

  // The cap keeps the sample count per bit at OVS when the bit period is not a multiple of it.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      sub_q <= '0;
      n_q   <= '0;
      pulse <= 1'b0;
    end else if (!en) begin
      pulse <= 1'b0;
    end else if (sub_q >= period - CNT_W'(1)) begin
      sub_q <= '0;
      pulse <= (n_q != NW'(OVS));
      if (n_q != NW'(OVS)) n_q <= n_q + NW'(1);
    end else begin
      sub_q <= sub_q + CNT_W'(1);
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_rate_gen.sv
// Programmable UART baud tick generator with glitch-free divisor update and RX phase sync.
// Define BAUD_FRAC_EN to add FRAC_W fractional divisor bits and the phase accumulator.
module baud_rate_gen
  import baud_pkg::*;
#(
  parameter int CLK_HZ = 10000000,
  parameter int BAUD   = 115200,
  parameter int CNT_W  = BAUD_CNT_W,
`ifdef BAUD_FRAC_EN
  parameter int FRAC_W = BAUD_FRAC_W,
`endif
  parameter int OVS    = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic SYNC,
  input  logic DIV_WE,
`ifdef BAUD_FRAC_EN
  input  logic [CNT_W+FRAC_W-1:0] DIV_IN,
`else
  input  logic [CNT_W-1:0] DIV_IN,
`endif
  output logic DIV_PEND,
  output logic DIV_ERR,
  output logic TICK,
  output logic HALF,
  output logic OVS_TICK
);

  localparam int OVS_SH = $clog2(OVS);
`ifdef BAUD_FRAC_EN
  localparam int DIV_W = CNT_W + FRAC_W;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(def_div(longint'(CLK_HZ), longint'(BAUD), FRAC_W));
`else
  localparam int DIV_W = CNT_W;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(def_div(longint'(CLK_HZ), longint'(BAUD), 0));
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d, div_int, in_int, last, half_pt, ovs_raw, ovs_per;
  logic [DIV_W-1:0] div_q, div_d, pend_val_q, pend_val_d;
  logic             pend_q, pend_d, wr_ok, run, wrap, ovs_clr;

  assign div_int = div_q[DIV_W-1 -: CNT_W];
  assign in_int  = DIV_IN[DIV_W-1 -: CNT_W];
  assign half_pt = (div_int >> 1) - CNT_W'(1);
  assign ovs_raw = div_int >> OVS_SH;
  assign ovs_per = (ovs_raw == '0) ? CNT_W'(1) : ovs_raw;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              stretch_q, stretch_d;

  assign last = div_int - CNT_W'(1) + CNT_W'(stretch_q);
`else
  assign last = div_int - CNT_W'(1);
`endif

  always_comb begin
    wr_ok      = DIV_WE && (in_int >= CNT_W'(2));
    run        = EN && !SYNC;
    wrap       = run && (cnt_q == last);
    div_d      = div_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    cnt_d      = cnt_q;
    if (SYNC || wrap) begin
      // A write landing on the boundary itself beats the older pending value.
      if (wr_ok)       div_d = DIV_IN;
      else if (pend_q) div_d = pend_val_q;
      pend_d = 1'b0;
      cnt_d  = '0;
    end else begin
      if (wr_ok && !EN) begin
        div_d  = DIV_IN;
        pend_d = 1'b0;
        if (cnt_q > in_int - CNT_W'(1)) cnt_d = in_int - CNT_W'(1);
      end else if (wr_ok) begin
        pend_d     = 1'b1;
        pend_val_d = DIV_IN;
      end
      if (run) cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef BAUD_FRAC_EN
  // Carry from the accumulator lengthens the period that starts at this wrap.
  always_comb begin
    acc_d     = acc_q;
    stretch_d = stretch_q;
    if (SYNC) begin
      acc_d     = '0;
      stretch_d = 1'b0;
    end else if (wrap) begin
      {stretch_d, acc_d} = {1'b0, acc_q} + {1'b0, div_d[FRAC_W-1:0]};
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q      <= '0;
      div_q      <= DEF_DIV;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      TICK       <= 1'b0;
      HALF       <= 1'b0;
      DIV_ERR    <= 1'b0;
`ifdef BAUD_FRAC_EN
      acc_q      <= '0;
      stretch_q  <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      TICK       <= wrap;
      HALF       <= run && (cnt_q == half_pt);
      DIV_ERR    <= DIV_WE && !wr_ok;
`ifdef BAUD_FRAC_EN
      acc_q      <= acc_d;
      stretch_q  <= stretch_d;
`endif
    end
  end

  assign DIV_PEND = pend_q;
  assign ovs_clr  = SYNC || wrap;

  baud_ovs_div #(
    .CNT_W (CNT_W),
    .OVS   (OVS)
  ) u_ovs (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (ovs_clr),
    .en     (EN),
    .period (ovs_per),
    .pulse  (OVS_TICK)
  );

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen; cycle 1 is the first cycle after RST is released.
// With BAUD_FRAC_EN defined only the reset and fractional-divisor sequences run.
module tb_baud_rate_gen;
  import baud_pkg::*;

`ifdef BAUD_FRAC_EN
  localparam int DW = BAUD_CNT_W + BAUD_FRAC_W;
`else
  localparam int DW = BAUD_CNT_W;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN = 1'b0;
  logic          SYNC = 1'b0;
  logic          DIV_WE = 1'b0;
  logic [DW-1:0] DIV_IN = '0;
  logic          DIV_PEND, DIV_ERR, TICK, HALF, OVS_TICK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int first_tick, first_half, n_tick, n_half, n_ovs;

  baud_rate_gen dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .SYNC     (SYNC),
    .DIV_WE   (DIV_WE),
    .DIV_IN   (DIV_IN),
    .DIV_PEND (DIV_PEND),
    .DIV_ERR  (DIV_ERR),
    .TICK     (TICK),
    .HALF     (HALF),
    .OVS_TICK (OVS_TICK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic observe(input int n);
    first_tick = -1; first_half = -1;
    n_tick = 0; n_half = 0; n_ovs = 0;
    repeat (n) begin
      step();
      if (TICK === 1'b1) begin n_tick++; if (first_tick < 0) first_tick = cyc; end
      if (HALF === 1'b1) begin n_half++; if (first_half < 0) first_half = cyc; end
      if (OVS_TICK === 1'b1) n_ovs++;
    end
  endtask

  task automatic wait_tick(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (TICK === 1'b1) begin at = cyc; break; end
    end
  endtask

  task automatic write_div(input int v);
    DIV_IN = DW'(v) << (DW - BAUD_CNT_W);
    DIV_WE = 1'b1;
    step();
    DIV_WE = 1'b0;
  endtask

  initial begin
    int tk [0:160];

    EN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_tick", TICK, 0);
    chk("rst_half", HALF, 0);
    chk("rst_ovs", OVS_TICK, 0);
    chk("rst_pend", DIV_PEND, 0);
    chk("rst_err", DIV_ERR, 0);
    RST = 1'b0;
    cyc = 1;

`ifdef BAUD_FRAC_EN
    EN = 1'b0;
    DIV_IN = {BAUD_CNT_W'(86), BAUD_FRAC_W'(8)};
    DIV_WE = 1'b1;
    step();
    DIV_WE = 1'b0;
    chk("frac_pend_en0", DIV_PEND, 0);
    EN = 1'b1;
    for (int k = 0; k <= 160; k++) wait_tick(200, tk[k]);
    chk("frac_first_tick", tk[0], 88);
    chk("frac_p2", tk[1] - tk[0], 86);
    chk("frac_p3", tk[2] - tk[1], 87);
    chk("frac_p4", tk[3] - tk[2], 86);
    chk("frac_160_periods", tk[160] - tk[0], 13840);
    chk("frac_no_timeout", (tk[160] > 0) ? 1 : 0, 1);
`else
    // Defaults: divisor 86, mid-bit 43, oversample period 5 capped at 16 per bit
    observe(86);
    chk("t1_first_tick", first_tick, 87);
    chk("t1_tick_cnt", n_tick, 1);
    chk("t1_first_half", first_half, 44);
    chk("t1_ovs_cnt", n_ovs, 16);
    observe(86);
    chk("t1_second_tick", first_tick, 173);
    chk("t1_second_half", first_half, 130);
    chk("t1_ovs_cnt2", n_ovs, 16);

    // Divisor 10 written at cnt=20; the running 86-cycle period finishes first
    observe(20);
    write_div(10);
    chk("t2_pend_set", DIV_PEND, 1);
    observe(64);
    chk("t2_pend_hold", DIV_PEND, 1);
    chk("t2_no_early_tick", n_tick, 0);
    step();
    chk("t2_old_tick", TICK, 1);
    chk("t2_pend_clr", DIV_PEND, 0);
    observe(10);
    chk("t2_new_tick1", first_tick, 269);
    chk("t2_new_half", first_half, 264);
    observe(10);
    chk("t2_new_tick2", first_tick, 279);

    // Back to 86, then a rejected write of 1
    write_div(86);
    observe(9);
    chk("t3_restore_tick", first_tick, 289);
    observe(11);
    write_div(1);
    chk("t3_err_pulse", DIV_ERR, 1);
    chk("t3_no_pend", DIV_PEND, 0);
    step();
    chk("t3_err_single", DIV_ERR, 0);
    observe(73);
    chk("t3_period_kept", first_tick, 375);

    // SYNC at cnt=40 restarts the bit
    observe(40);
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    chk("t4_sync_no_tick", TICK, 0);
    chk("t4_sync_no_half", HALF, 0);
    observe(86);
    chk("t4_sync_tick", first_tick, 502);

    // EN low for 20 cycles at cnt=10
    observe(10);
    EN = 1'b0;
    observe(20);
    chk("t4_en0_no_tick", n_tick + n_half + n_ovs, 0);
    EN = 1'b1;
    observe(76);
    chk("t4_en0_tick", first_tick, 608);
    chk("t4_en0_half", first_half, 565);

    // SYNC on the terminal count wins over the wrap
    observe(85);
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    chk("t4_sync_term_no_tick", TICK, 0);
    chk("t4_sync_term_no_ovs", OVS_TICK, 0);
    observe(86);
    chk("t4_sync_term_tick", first_tick, 780);

    // Pending divisor applied by SYNC
    observe(10);
    write_div(20);
    chk("t4_pend_before_sync", DIV_PEND, 1);
    observe(9);
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    chk("t4_pend_sync_clr", DIV_PEND, 0);
    observe(20);
    chk("t4_pend_sync_tick", first_tick, 821);

    // Write with EN low takes effect immediately
    EN = 1'b0;
    write_div(30);
    chk("t4_en0_write_no_pend", DIV_PEND, 0);
    EN = 1'b1;
    observe(30);
    chk("t4_en0_write_tick", first_tick, 852);

    // Reset while a write is pending
    write_div(50);
    chk("t6_pend_set", DIV_PEND, 1);
    RST = 1'b1;
    step();
    chk("t6_pend_lost", DIV_PEND, 0);
    chk("t6_tick0", TICK, 0);
    chk("t6_half0", HALF, 0);
    chk("t6_ovs0", OVS_TICK, 0);
    RST = 1'b0;
    cyc = 1;
    observe(86);
    chk("t6_def_tick", first_tick, 87);
    chk("t6_def_ovs", n_ovs, 16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
